uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one UART transmit line between NREQ byte sources. Round-robin arbiter
//   accepts one byte per grant and serialises it as 8N1, LSB first.
//   Bit timing comes from a single-cycle baud enable tick, not a derived clock;
//   all logic runs on clk. Sits between console/debug producers and the board TX pin.
// PARAMETERS
//   CLK_HZ  100_000_000  input clock frequency, Hz
//   BAUD    9600         line rate, bits/s
//   NREQ    4            number of requesters, >=2
//   DIV     (CLK_HZ+BAUD/2)/BAUD  localparam: clk cycles per bit (10417 at default); must be >=2
// PORTS
//   clk        in   1        system clock
//   reset      in   1        asynchronous, active-high
//   req_valid  in   NREQ     requester i has a byte pending
//   req_data   in   NREQ*8   byte of requester i at [8*i+7:8*i]; held stable while valid
//   req_ready  out  NREQ     one-hot, 1-cycle pulse: byte of requester i accepted
//   tx         out  1        serial line; idles high
//   busy       out  1        high from accept cycle through last stop-bit cycle
//   grant_id   out  clog2(NREQ)  index of requester owning current/last frame
//   frame_done out  1        1-cycle pulse on last cycle of stop bit
// BEHAVIOUR
//   Reset: tx=1, busy=0, req_ready=0, grant_id=0, frame_done=0, rr_ptr=0, baud cnt=0, state IDLE.
//   Reset mid-frame aborts immediately; tx returns high asynchronously; byte is lost, no frame_done.
//   Baud counter: counts 0..DIV-1 while busy; tick when cnt==DIV-1, then wraps to 0.
//     Cleared to 0 on accept, so every bit is exactly DIV cycles. Idle: held at 0.
//   States: IDLE -> START -> DATA(8 bits) -> [PARITY] -> STOP -> IDLE.
//   IDLE: if any req_valid, pick first valid index at or after rr_ptr (wrap mod NREQ);
//     same cycle pulse req_ready[k], latch req_data[k], grant_id<=k, busy<=1, go START.
//     No valid: stay, tx=1.
//   START: tx=0 for DIV cycles. DATA: tx=shift[0], bit index 0..7, shift on tick.
//   STOP: tx=1 for DIV cycles; on its tick frame_done=1, rr_ptr<=(grant_id+1) mod NREQ,
//     busy<=0, go IDLE. Next accept no earlier than the following cycle (1-clk gap).
//   Frame length: 10*DIV cycles (11*DIV with parity) from accept to frame_done, inclusive.
//   Requesters dropping valid before grant are simply skipped; no ready issued.
//   req_valid changes while busy are ignored; arbitration only in IDLE.
//   tx is driven from a register (glitch-free), changes only on state/tick edges.
// CONFIGURATION
//   UART_TX_PARITY_EN defined: PARITY state after DATA, tx = even parity (^byte)
//     for DIV cycles; frame 8E1.
//   Undefined: no PARITY state; DATA goes directly to STOP; frame 8N1.
// STRUCTURE
//   Package uart_pkg: state enum (IDLE,START,DATA,PARITY,STOP), DATA_BITS=8,
//     function computing DIV from CLK_HZ/BAUD with rounding.
//   Sub-module uart_baud_tick (params DIV; ports clk, reset, clr, en, tick):
//     the bit-period counter. Arbiter + FSM + shifter stay in this module.
// TESTING  (CLK_HZ=1_000_000, BAUD=100_000 -> DIV=10, NREQ=4)
//   req0 sends 0xA5 -> tx: 0 then 1,0,1,0,0,1,0,1 then 1, each 10 clks;
//     frame_done 100 clks after accept; req_ready[0] one pulse.
//   All 4 valid continuously -> grant order 0,1,2,3,0; gap between frame_done
//     and next req_ready exactly 1 clk.
//   rr_ptr=2, only req1 and req3 valid -> req3 granted first, then req1.
//   Assert reset at clk 35 of a frame -> tx=1 same cycle, busy=0,
//     no frame_done; after release, req0 retransmits full 100-clk frame.
//   Idle with no valid for 50 clks -> tx=1, busy=0, req_ready=0 throughout.
//   UART_TX_PARITY_EN: send 0x07 -> parity bit 1 after data, frame 110 clks;
//     send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the arbitrated UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int DATA_BITS = 8;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 while enabled and flags the last cycle of each bit.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined).
// Handshake: a requester holds req_valid/req_data until it sees its one-cycle req_ready pulse.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600,
    parameter int NREQ   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*8-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    tx,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    frame_done,
    output state_t                  fsm_state
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int GW  = $clog2(NREQ);

    state_t                 state;
    logic [GW-1:0]          rr_ptr;
    logic [DATA_BITS-1:0]   shift;
    logic [2:0]             bit_idx;
    logic                   tick;
    logic                   accept;
`ifdef UART_TX_PARITY_EN
    logic                   parity;
`endif

    logic                   lo_found;
    logic                   hi_found;
    logic [GW-1:0]          lo_pick;
    logic [GW-1:0]          hi_pick;
    logic [7:0]             lo_byte;
    logic [7:0]             hi_byte;
    logic [GW-1:0]          pick;
    logic [7:0]             sel_byte;

    // Two passes in one loop: first valid at/after rr_ptr wins, else first valid overall (wrap).
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_pick  = '0;
        hi_pick  = '0;
        lo_byte  = '0;
        hi_byte  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_pick  = GW'(i);
                lo_byte  = req_data[8*i +: 8];
            end
            if (req_valid[i] && !hi_found && (i >= int'(rr_ptr))) begin
                hi_found = 1'b1;
                hi_pick  = GW'(i);
                hi_byte  = req_data[8*i +: 8];
            end
        end
        pick     = hi_found ? hi_pick : lo_pick;
        sel_byte = hi_found ? hi_byte : lo_byte;
    end

    assign accept     = (state == IDLE) && (|req_valid);
    assign frame_done = (state == STOP) && tick;
    assign fsm_state  = state;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (busy),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            req_ready <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
            shift     <= '0;
            bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            req_ready <= '0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (accept) begin
                        req_ready <= NREQ'(1) << pick;
                        shift     <= sel_byte;
                        grant_id  <= pick;
                        busy      <= 1'b1;
                        tx        <= 1'b0;
                        state     <= START;
`ifdef UART_TX_PARITY_EN
                        parity    <= ^sel_byte;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        tx      <= shift[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx      <= shift[1];
                            shift   <= {1'b0, shift[DATA_BITS-1:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        busy   <= 1'b0;
                        rr_ptr <= (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + GW'(1);
                        state  <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at DIV=10, NREQ=4; honours UART_TX_PARITY_EN.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NREQ = 4;
    localparam int DIV  = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * DIV;

    logic            clk;
    logic            reset;
    logic [NREQ-1:0] req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0] req_ready;
    logic            tx;
    logic            busy;
    logic [1:0]      grant_id;
    logic            frame_done;
    state_t          fsm_state;

    int n_total;
    int n_bad;
    int cyc;
    logic [1:0] exp_q[$];

    uart_tx_arbiter #(
        .CLK_HZ (1_000_000),
        .BAUD   (100_000),
        .NREQ   (NREQ)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx         (tx),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done),
        .fsm_state  (fsm_state)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every ready pulse must match the next expected grant
    always @(negedge clk) begin
        if (!reset && req_ready != '0) begin
            if (exp_q.size() == 0) begin
                check("grant_unexpected", 32'(req_ready), 32'h0);
            end else begin
                logic [1:0] e;
                logic [3:0] one;
                e = exp_q.pop_front();
                one = 4'b0001;
                check("grant_ready", 32'(req_ready), 32'(one << e));
                check("grant_id", 32'(grant_id), 32'(e));
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag, output int c);
        c = -1;
        for (int k = 0; k < 2 * FL; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) check({tag, "_ready_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic wait_done(input string tag, output int d);
        d = -1;
        for (int k = 0; k < 2 * FL; k++) begin
            @(negedge clk);
            if (frame_done) begin
                d = cyc;
                break;
            end
        end
        if (d < 0) check({tag, "_done_timeout"}, 32'h0, 32'h1);
    endtask

    // driver: one byte from requester idx, line checked mid-bit against a hand-built pattern
    task automatic send_frame(input int idx, input logic [7:0] data, input logic [10:0] exp_line,
                              input string tag);
        int c;
        int d;
        req_data[8*idx +: 8] = data;
        req_valid[idx] = 1'b1;
        exp_q.push_back(2'(idx));
        wait_ready(tag, c);
        req_valid[idx] = 1'b0;
        if (c < 0) return;
        check({tag, "_busy_accept"}, 32'(busy), 32'h1);
        for (int b = 0; b < NBITS; b++) begin
            wait_cyc(c + DIV * b + 5);
            check($sformatf("%s_bit%0d", tag, b), 32'(tx), 32'(exp_line[b]));
        end
        wait_done(tag, d);
        if (d < 0) return;
        check({tag, "_done_offset"}, 32'(d - c), 32'(FL - 1));
        check({tag, "_busy_last"}, 32'(busy), 32'h1);
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 32'h0);
        check({tag, "_tx_after"}, 32'(tx), 32'h1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c;
        int d;
        int prev_d;
        logic bad_idle;
        cyc = 0;
        n_total = 0;
        n_bad = 0;
        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_grant", 32'(grant_id), 32'h0);
        check("rst_done", 32'(frame_done), 32'h0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        reset = 1'b0;

        // idle with nothing pending
        bad_idle = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== '0) bad_idle = 1'b1;
        end
        check("idle_quiet", 32'(bad_idle), 32'h0);

`ifdef UART_TX_PARITY_EN
        send_frame(0, 8'hA5, 11'h54A, "a5");
`else
        send_frame(0, 8'hA5, 11'h34A, "a5");
`endif

        // reset part-way through a frame of 0x00 from req0
        pulse_reset();
        req_data[7:0] = 8'h00;
        req_valid = 4'b0001;
        exp_q.push_back(2'd0);
        wait_ready("abort", c);
        if (c >= 0) begin
            wait_cyc(c + 35);
            check("abort_tx_before", 32'(tx), 32'h0);
            reset = 1'b1;
            #1;
            check("abort_tx", 32'(tx), 32'h1);
            check("abort_busy", 32'(busy), 32'h0);
            check("abort_done", 32'(frame_done), 32'h0);
            repeat (2) @(negedge clk);
            exp_q.push_back(2'd0);
            reset = 1'b0;
            wait_ready("retx", c);
            req_valid = '0;
            wait_done("retx", d);
            if (c >= 0 && d >= 0) check("retx_offset", 32'(d - c), 32'(FL - 1));
        end

        // all four requesters continuously valid after a fresh reset
        pulse_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        prev_d = -1;
        for (int f = 0; f < 5; f++) begin
            wait_ready($sformatf("rr%0d", f), c);
            if (f == 4) req_valid = '0;
            if (c < 0) break;
            if (prev_d >= 0) check($sformatf("rr%0d_gap", f), 32'(c - prev_d), 32'h2);
            wait_done($sformatf("rr%0d", f), d);
            if (d < 0) break;
            check($sformatf("rr%0d_offset", f), 32'(d - c), 32'(FL - 1));
            prev_d = d;
        end

        // rr_ptr is 1 here; a lone req1 frame moves it to 2
        req_valid = '0;
        req_data[15:8] = 8'h5A;
        req_valid[1] = 1'b1;
        exp_q.push_back(2'd1);
        wait_ready("solo1", c);
        req_valid[1] = 1'b0;
        wait_done("solo1", d);

        // rr_ptr=2 with req1 and req3 pending: 3 wins, then 1
        req_valid = 4'b1010;
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        wait_ready("skip3", c);
        req_valid[3] = 1'b0;
        wait_done("skip3", d);
        wait_ready("skip1", c);
        req_valid[1] = 1'b0;
        wait_done("skip1", d);

`ifdef UART_TX_PARITY_EN
        send_frame(2, 8'h07, 11'h60E, "par07");
        send_frame(2, 8'h03, 11'h406, "par03");
`endif

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'h0);
        check("end_busy", 32'(busy), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
